vram_sram_responder: RTL and testbench

- Responder end of the renderer VRAM read/write port: accepts single-cycle read/write requests on 24-bit tuples (two 12-bit RGB444 pixels) at 20-bit tuple addresses.
- Executes each request as two accesses on an external 12-bit asynchronous SRAM.
- Returns a data-valid pulse for reads and a done pulse for writes.
- Sits between the renderer stages (rect fill/mix, copy) and the SRAM pins.

---
 rtl/vram_sram_responder_if.sv | 26 ++
 rtl/vram_sram_responder.sv | 199 +++++++++++++++++++
 tb/tb_vram_sram_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_sram_responder_if.sv
`default_nettype none
// ======================================================================
// vram_sram_responder_if : renderer-side VRAM tuple read/write port.
// Rev 1.0
// ======================================================================
interface vram_sram_responder_if;
   logic [19:0] read_address;
   logic        read_request;
   logic [23:0] read_data;
   logic        read_data_valid;
   logic [19:0] write_address;
   logic [23:0] write_data;
   logic        write_request;
   logic        write_done;

   modport master (
      output read_address, read_request, write_address, write_data, write_request,
      input  read_data, read_data_valid, write_done
   );

   modport slave (
      input  read_address, read_request, write_address, write_data, write_request,
      output read_data, read_data_valid, write_done
   );
endinterface
`default_nettype wire

// File: rtl/vram_sram_responder.sv
`default_nettype none
// ======================================================================
// vram_sram_responder : VRAM tuple port to 12-bit async SRAM, two accesses
// per tuple. Optional read-after-write bypass: RENDERER_VRAM_WRITE_BYPASS_EN.
// Rev 1.0
// ======================================================================
module vram_sram_responder #(
   parameter int WAIT_STATES = 1
) (
   input  logic                 i_master_clk,
   input  logic                 i_reset_n,
   vram_sram_responder_if.slave vram,
   output logic [20:0]          o_sram_address,
   output logic [11:0]          o_sram_data,
   output logic                 o_sram_data_oe,
   input  logic [11:0]          i_sram_data,
   output logic                 o_sram_oe_n,
   output logic                 o_sram_we_n,
   output logic                 o_protocol_error
);
   localparam logic [2:0] c_idle    = 3'd0;
   localparam logic [2:0] c_rd_lo   = 3'd1;
   localparam logic [2:0] c_rd_hi   = 3'd2;
   localparam logic [2:0] c_rd_done = 3'd3;
   localparam logic [2:0] c_wr_lo   = 3'd4;
   localparam logic [2:0] c_wr_hi   = 3'd5;
   localparam logic [2:0] c_wr_done = 3'd6;
`ifdef RENDERER_VRAM_WRITE_BYPASS_EN
   localparam logic [2:0] c_rd_byp  = 3'd7;
`endif
   localparam logic [2:0] c_last_phase = 3'(WAIT_STATES);

   logic [2:0]  state_q, state_d;
   logic [2:0]  phase_q, phase_d;
   logic        rd_pend_q, rd_pend_d;
   logic        wr_pend_q, wr_pend_d;
   logic [19:0] rd_addr_q, rd_addr_d;
   logic [19:0] wr_addr_q, wr_addr_d;
   logic [23:0] wr_data_q, wr_data_d;
   logic [11:0] lo_buf_q, lo_buf_d;
   logic [23:0] read_data_q, read_data_d;
   logic        valid_q, valid_d;
   logic        done_q, done_d;
   logic [20:0] sram_addr_q, sram_addr_d;
   logic [11:0] sram_data_q, sram_data_d;
   logic        data_oe_q, data_oe_d;
   logic        oe_n_q, oe_n_d;
   logic        we_n_q, we_n_d;
   logic        proto_err_q, proto_err_d;
`ifdef RENDERER_VRAM_WRITE_BYPASS_EN
   logic        byp_vld_q, byp_vld_d;
   logic [19:0] byp_addr_q, byp_addr_d;
   logic [23:0] byp_data_q, byp_data_d;
`endif

   logic        w_rd_busy, w_wr_busy, w_rd_accept, w_wr_accept;
   logic        w_phase_end, w_rd_phase, w_wr_phase, w_hi_phase;
   logic [2:0]  w_rd_start;

   always_comb begin
      // A slot in its DONE state is being released, so a same-cycle request refills it.
      w_rd_busy   = rd_pend_q && (state_q != c_rd_done);
      w_wr_busy   = wr_pend_q && (state_q != c_wr_done);
      w_rd_accept = vram.read_request && !w_rd_busy;
      w_wr_accept = vram.write_request && !w_wr_busy;
      rd_pend_d   = w_rd_busy || w_rd_accept;
      wr_pend_d   = w_wr_busy || w_wr_accept;
      rd_addr_d   = w_rd_accept ? vram.read_address  : rd_addr_q;
      wr_addr_d   = w_wr_accept ? vram.write_address : wr_addr_q;
      wr_data_d   = w_wr_accept ? vram.write_data    : wr_data_q;
      proto_err_d = proto_err_q || (vram.read_request && w_rd_busy)
                                || (vram.write_request && w_wr_busy);
      w_phase_end = (phase_q == c_last_phase);

`ifdef RENDERER_VRAM_WRITE_BYPASS_EN
      byp_vld_d  = byp_vld_q;
      byp_addr_d = byp_addr_q;
      byp_data_d = byp_data_q;
      if (state_q == c_wr_done) begin
         byp_vld_d  = 1'b1;
         byp_addr_d = wr_addr_q;
         byp_data_d = wr_data_q;
      end
      w_rd_start = (byp_vld_d && (byp_addr_d == rd_addr_d) && !wr_pend_d) ? c_rd_byp : c_rd_lo;
`else
      w_rd_start = c_rd_lo;
`endif

      state_d = state_q;
      case (state_q)
         c_idle, c_rd_done: begin
            if (wr_pend_d)      state_d = c_wr_lo;
            else if (rd_pend_d) state_d = w_rd_start;
            else                state_d = c_idle;
         end
         c_rd_lo:   if (w_phase_end) state_d = c_rd_hi;
         c_rd_hi:   if (w_phase_end) state_d = c_rd_done;
         c_wr_lo:   if (w_phase_end) state_d = c_wr_hi;
         c_wr_hi:   if (w_phase_end) state_d = c_wr_done;
         c_wr_done: begin
            if (rd_pend_d)      state_d = w_rd_start;
            else if (wr_pend_d) state_d = c_wr_lo;
            else                state_d = c_idle;
         end
`ifdef RENDERER_VRAM_WRITE_BYPASS_EN
         c_rd_byp:  state_d = c_rd_done;
`endif
         default:   state_d = c_idle;
      endcase
      phase_d = (state_d != state_q) ? 3'd0 : phase_q + 3'd1;

      lo_buf_d    = lo_buf_q;
      read_data_d = read_data_q;
      if (state_q == c_rd_lo && w_phase_end) lo_buf_d = i_sram_data;
      if (state_q == c_rd_hi && w_phase_end) read_data_d = {i_sram_data, lo_buf_q};
`ifdef RENDERER_VRAM_WRITE_BYPASS_EN
      if (state_q == c_rd_byp) read_data_d = byp_data_q;
`endif
      valid_d = (state_d == c_rd_done);
      done_d  = (state_d == c_wr_done);

      // Pin values are decoded from the next state so they register in step with it.
      w_rd_phase  = (state_d == c_rd_lo) || (state_d == c_rd_hi);
      w_wr_phase  = (state_d == c_wr_lo) || (state_d == c_wr_hi);
      w_hi_phase  = (state_d == c_rd_hi) || (state_d == c_wr_hi);
      sram_addr_d = sram_addr_q;
      sram_data_d = sram_data_q;
      if (w_rd_phase) sram_addr_d = {rd_addr_d, w_hi_phase};
      if (w_wr_phase) begin
         sram_addr_d = {wr_addr_d, w_hi_phase};
         sram_data_d = w_hi_phase ? wr_data_d[23:12] : wr_data_d[11:0];
      end
      oe_n_d    = !w_rd_phase;
      we_n_d    = !(w_wr_phase && (phase_d != 3'd0));
      data_oe_d = w_wr_phase;
   end

   always_ff @(posedge i_master_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= c_idle;
         phase_q     <= 3'd0;
         rd_pend_q   <= 1'b0;
         wr_pend_q   <= 1'b0;
         rd_addr_q   <= 20'd0;
         wr_addr_q   <= 20'd0;
         wr_data_q   <= 24'd0;
         lo_buf_q    <= 12'd0;
         read_data_q <= 24'd0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         sram_addr_q <= 21'd0;
         sram_data_q <= 12'd0;
         data_oe_q   <= 1'b0;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         proto_err_q <= 1'b0;
`ifdef RENDERER_VRAM_WRITE_BYPASS_EN
         byp_vld_q   <= 1'b0;
         byp_addr_q  <= 20'd0;
         byp_data_q  <= 24'd0;
`endif
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         rd_pend_q   <= rd_pend_d;
         wr_pend_q   <= wr_pend_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         lo_buf_q    <= lo_buf_d;
         read_data_q <= read_data_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         sram_addr_q <= sram_addr_d;
         sram_data_q <= sram_data_d;
         data_oe_q   <= data_oe_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         proto_err_q <= proto_err_d;
`ifdef RENDERER_VRAM_WRITE_BYPASS_EN
         byp_vld_q   <= byp_vld_d;
         byp_addr_q  <= byp_addr_d;
         byp_data_q  <= byp_data_d;
`endif
      end
   end

   assign vram.read_data       = read_data_q;
   assign vram.read_data_valid = valid_q;
   assign vram.write_done      = done_q;
   assign o_sram_address       = sram_addr_q;
   assign o_sram_data          = sram_data_q;
   assign o_sram_data_oe       = data_oe_q;
   assign o_sram_oe_n          = oe_n_q;
   assign o_sram_we_n          = we_n_q;
   assign o_protocol_error     = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_sram_responder.sv
`default_nettype none
// ======================================================================
// tb_vram_sram_responder : scoreboard bench with a behavioural async SRAM.
// Rev 1.0
// ======================================================================
module tb_vram_sram_responder;
   localparam int WS = 1;

   logic        clk;
   logic        rst_n;
   logic [20:0] sram_addr;
   logic [11:0] sram_dout;
   logic [11:0] sram_din;
   logic        sram_doe;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic        proto_err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      bit          is_wr;
      logic [23:0] data;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   logic [11:0] mem [logic [20:0]];

   vram_sram_responder_if vif ();

   vram_sram_responder #(.WAIT_STATES(WS)) dut (
      .i_master_clk     (clk),
      .i_reset_n        (rst_n),
      .vram             (vif),
      .o_sram_address   (sram_addr),
      .o_sram_data      (sram_dout),
      .o_sram_data_oe   (sram_doe),
      .i_sram_data      (sram_din),
      .o_sram_oe_n      (sram_oe_n),
      .o_sram_we_n      (sram_we_n),
      .o_protocol_error (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   always @(*) begin
      sram_din = 12'h000;
      if (!sram_oe_n && mem.exists(sram_addr)) sram_din = mem[sram_addr];
   end

   always @(negedge clk) begin
      if (!sram_we_n && sram_doe) mem[sram_addr] = sram_dout;
   end

   // Monitor: every valid/done pulse is matched against the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      checks = checks + 1;
      if (sram_oe_n === 1'b0 && sram_we_n === 1'b0) begin
         failures = failures + 1;
         $display("FAIL oe_we_overlap cyc=%0d oe_n=%0b we_n=%0b required=not both low", cyc, sram_oe_n, sram_we_n);
      end
      if (vif.read_data_valid === 1'b1 || vif.write_done === 1'b1) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL unexpected_event cyc=%0d valid=%0b done=%0b required=none", cyc,
                     vif.read_data_valid, vif.write_done);
         end else begin
            e = exp_q.pop_front();
            if ({vif.read_data_valid, vif.write_done} !== (e.is_wr ? 2'b01 : 2'b10) ||
                cyc != e.cyc || (!e.is_wr && vif.read_data !== e.data)) begin
               failures = failures + 1;
               $display("FAIL event actual valid=%0b done=%0b cyc=%0d data=%h required is_wr=%0b cyc=%0d data=%h",
                        vif.read_data_valid, vif.write_done, cyc, vif.read_data, e.is_wr, e.cyc, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         failures = failures + 1;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic expect_ev(input bit w, input logic [23:0] d, input int c);
      exp_t e;
      e.is_wr = w;
      e.data  = d;
      e.cyc   = c;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; the request occupies cycle rc.
   task automatic issue(input bit rd, input logic [19:0] ra, input bit wr, input logic [19:0] wa,
                        input logic [23:0] wd, output int rc);
      vif.read_address  = ra;
      vif.read_request  = rd;
      vif.write_address = wa;
      vif.write_data    = wd;
      vif.write_request = wr;
      rc = cyc;
      tick();
      vif.read_request  = 1'b0;
      vif.write_request = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      tick();
      tick();
   endtask

   logic [20:0] wr_addr_tab [5] = '{21'h0020A, 21'h0020A, 21'h0020B, 21'h0020B, 21'h0020B};
   logic [11:0] wr_data_tab [5] = '{12'h123, 12'h123, 12'hABC, 12'hABC, 12'hABC};
   logic        wr_wen_tab  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic        wr_doe_tab  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      int r;
      vif.read_address  = '0;
      vif.read_request  = 1'b0;
      vif.write_address = '0;
      vif.write_data    = '0;
      vif.write_request = 1'b0;
      mem[21'h0020A] = 12'h456;
      mem[21'h0020B] = 12'h789;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_read_data", {8'h0, vif.read_data}, 32'h0);
      chk("rst_valid", {31'h0, vif.read_data_valid}, 32'h0);
      chk("rst_done", {31'h0, vif.write_done}, 32'h0);
      chk("rst_sram_addr", {11'h0, sram_addr}, 32'h0);
      chk("rst_sram_data", {20'h0, sram_dout}, 32'h0);
      chk("rst_data_oe", {31'h0, sram_doe}, 32'h0);
      chk("rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
      chk("rst_we_n", {31'h0, sram_we_n}, 32'h1);
      chk("rst_proto_err", {31'h0, proto_err}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Read of preloaded tuple: 0x789 high, 0x456 low.
      issue(1'b1, 20'h00105, 1'b0, 20'h0, 24'h0, r);
      expect_ev(1'b0, 24'h789456, r + 5);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk("rd_oe_n", {31'h0, sram_oe_n}, (i < 5) ? 32'h0 : 32'h1);
         if (i < 5) chk("rd_addr", {11'h0, sram_addr}, (i < 3) ? 32'h20A : 32'h20B);
      end
      drain();

      // Write 0xABC123 to 0x00105 with pin-level trace.
      issue(1'b0, 20'h0, 1'b1, 20'h00105, 24'hABC123, r);
      expect_ev(1'b1, 24'h0, r + 5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) begin
            chk("wr_addr", {11'h0, sram_addr}, {11'h0, wr_addr_tab[i]});
            chk("wr_data", {20'h0, sram_dout}, {20'h0, wr_data_tab[i]});
         end
         chk("wr_we_n", {31'h0, sram_we_n}, {31'h0, wr_wen_tab[i]});
         chk("wr_data_oe", {31'h0, sram_doe}, {31'h0, wr_doe_tab[i]});
      end
      drain();
      issue(1'b1, 20'h00105, 1'b0, 20'h0, 24'h0, r);
      expect_ev(1'b0, 24'hABC123, r + 5);
      drain();

      // Simultaneous read and write: write wins, read follows.
      issue(1'b1, 20'h00105, 1'b1, 20'h00300, 24'h135246, r);
      expect_ev(1'b1, 24'h0, r + 5);
      expect_ev(1'b0, 24'hABC123, r + 10);
      drain();
      chk("simul_proto_err", {31'h0, proto_err}, 32'h0);

      // Second write while the first is still queued behind a read.
      issue(1'b1, 20'h00300, 1'b0, 20'h0, 24'h0, r);
      expect_ev(1'b0, 24'h135246, r + 5);
      expect_ev(1'b1, 24'h0, r + 10);
      issue(1'b0, 20'h0, 1'b1, 20'h00400, 24'h111222, r);
      issue(1'b0, 20'h0, 1'b1, 20'h00500, 24'h333444, r);
      drain();
      chk("dup_proto_err", {31'h0, proto_err}, 32'h1);
      issue(1'b1, 20'h00500, 1'b0, 20'h0, 24'h0, r);
      expect_ev(1'b0, 24'h000000, r + 5);
      drain();

      // Reset asserted while WR_HI drives we_n low.
      issue(1'b0, 20'h0, 1'b1, 20'h00200, 24'h777888, r);
      repeat (4) @(negedge clk);
      chk("abort_in_wr_hi", {31'h0, sram_we_n}, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_we_n", {31'h0, sram_we_n}, 32'h1);
      chk("abort_data_oe", {31'h0, sram_doe}, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("abort_proto_err", {31'h0, proto_err}, 32'h0);
      issue(1'b1, 20'h00400, 1'b0, 20'h0, 24'h0, r);
      expect_ev(1'b0, 24'h111222, r + 5);
      drain();

      // Read of the last written tuple: bypassed when the feature is built in.
      issue(1'b0, 20'h0, 1'b1, 20'h00010, 24'h0F0F0F, r);
      expect_ev(1'b1, 24'h0, r + 5);
      drain();
      issue(1'b1, 20'h00010, 1'b0, 20'h0, 24'h0, r);
`ifdef RENDERER_VRAM_WRITE_BYPASS_EN
      expect_ev(1'b0, 24'h0F0F0F, r + 2);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk("byp_oe_n", {31'h0, sram_oe_n}, 32'h1);
      end
`else
      expect_ev(1'b0, 24'h0F0F0F, r + 5);
`endif
      drain();
      issue(1'b1, 20'h00011, 1'b0, 20'h0, 24'h0, r);
      expect_ev(1'b0, 24'h000000, r + 5);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
